// File: rtl/rx_spart_if.sv
// Processor-side bus of the SPART receive half: read strobe/address in,
// received byte and status flags out.
interface rx_spart_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 iorw;
  logic [1:0]           ioaddr;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rda;
  logic                 ferr;
  logic                 overrun;

  // Receiver side
  modport slave (
    input  iorw,
    input  ioaddr,
    output rx_data,
    output rda,
    output ferr,
    output overrun
  );

  // Processor side
  modport master (
    output iorw,
    output ioaddr,
    input  rx_data,
    input  rda,
    input  ferr,
    input  overrun
  );
endinterface

// File: rtl/rx_spart.sv
// SPART receive half: 16x oversampled UART receiver (1 start, DATA_BITS data LSB first,
// 1 stop, no parity) with receive-data-available and sticky overrun flags.
// Optional macro RX_FERR_EN: when defined, the stop bit drives a framing-error flag;
// when undefined, the stop bit is ignored and ferr is tied low.
module rx_spart #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input logic        clk,
  input logic        rst,
  input logic        rxd,
  input logic        brg_en16,
  rx_spart_if.slave  bus
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [1:0]           rxd_sync_d, rxd_sync_q;
  logic                 rxd_s;
  logic [1:0]           state_d, state_q;
  logic [TickW-1:0]     tick_d, tick_q;
  logic [BitW-1:0]      bit_d, bit_q;
  logic [DATA_BITS-1:0] shift_d, shift_q;
  logic [DATA_BITS-1:0] rx_data_d, rx_data_q;
  logic                 rda_d, rda_q;
  logic                 overrun_d, overrun_q;
  logic                 done;
  logic                 rd;

  assign rxd_s = rxd_sync_q[1];
  assign rd    = bus.iorw && (bus.ioaddr == 2'b00);

  // Frame FSM: start detect, mid-bit sampling, shift-in and stop-bit completion
  always_comb begin
    rxd_sync_d = {rxd_sync_q[0], rxd};
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rxd_s) begin
          state_d = StStart;
          tick_d  = '0;
        end
      end
      StStart: begin
        if (brg_en16) begin
          if (tick_q == TickMid) begin
            tick_d  = '0;
            bit_d   = '0;
            // A high line at mid start bit is a glitch, not a frame
            state_d = rxd_s ? StIdle : StData;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      StData: begin
        if (brg_en16) begin
          if (tick_q == TickLast) begin
            tick_d  = '0;
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == BitLast) state_d = StStop;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (brg_en16) begin
          if (tick_q == TickLast) begin
            tick_d  = '0;
            done    = 1'b1;
            state_d = StIdle;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Buffer/flag update; a completing byte takes priority over a concurrent read
  always_comb begin
    rx_data_d = rx_data_q;
    rda_d     = rda_q;
    overrun_d = overrun_q;
    if (rd) begin
      rda_d     = 1'b0;
      overrun_d = 1'b0;
    end
    if (done) begin
      rx_data_d = shift_q;
      rda_d     = 1'b1;
      if (rda_q && !rd) overrun_d = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_sync_q <= 2'b11;
      state_q    <= StIdle;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rda_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rxd_sync_q <= rxd_sync_d;
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rda_q      <= rda_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.rda     = rda_q;
  assign bus.overrun = overrun_q;

`ifdef RX_FERR_EN
  logic ferr_d, ferr_q;

  // Framing error reflects the stop bit of the most recent completed frame
  always_comb begin
    ferr_d = ferr_q;
    if (done) ferr_d = ~rxd_s;
  end

  // Framing error register
  always_ff @(posedge clk) begin
    if (rst) ferr_q <= 1'b0;
    else     ferr_q <= ferr_d;
  end

  assign bus.ferr = ferr_q;
`else
  assign bus.ferr = 1'b0;
`endif

endmodule

// File: tb/tb_rx_spart.sv
// Self-checking bench for rx_spart: drives serial frames on rxd and checks the bus-side
// buffer/flags against a frame-level model (byte arrives -> rda set, overrun if unread).
module tb_rx_spart;

  logic clk = 1'b0;
  logic rst;
  logic rxd;
  logic brg_en16;

  rx_spart_if bus ();

  rx_spart dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .brg_en16 (brg_en16),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model of the processor-visible state
  logic [7:0] m_data;
  logic       m_rda, m_ferr, m_ovr;

  // Baud generator stand-in: one tick every 4 clocks
  initial begin
    int c;
    c = 0;
    brg_en16 = 1'b0;
    forever begin
      @(negedge clk);
      brg_en16 = (c == 3);
      c = (c + 1) % 4;
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (brg_en16 !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic drive_line(input logic b, input int ticks);
    @(negedge clk);
    rxd = b;
    wait_ticks(ticks);
  endtask

  task automatic send_start_data(input logic [7:0] d);
    drive_line(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_line(d[i], 16);
  endtask

  // A low stop bit is held only 12 ticks so the following false start dies cleanly
  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_start_data(d);
    if (stop) begin
      drive_line(1'b1, 16);
    end else begin
      drive_line(1'b0, 12);
      drive_line(1'b1, 12);
    end
    drive_line(1'b1, 4);
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop);
    if (m_rda) m_ovr = 1'b1;
    m_data = d;
    m_rda  = 1'b1;
`ifdef RX_FERR_EN
    m_ferr = ~stop;
`else
    m_ferr = 1'b0;
    if (stop === 1'bx) m_ferr = 1'b0;
`endif
  endtask

  task automatic do_read();
    @(negedge clk);
    bus.iorw   = 1'b1;
    bus.ioaddr = 2'b00;
    @(negedge clk);
    bus.iorw   = 1'b0;
    bus.ioaddr = 2'b11;
    m_rda = 1'b0;
    m_ovr = 1'b0;
  endtask

  // Bus cycle that must not affect the receiver: a write, or a read of another address
  task automatic do_noop(input logic is_write, input logic [1:0] addr);
    @(negedge clk);
    bus.iorw   = ~is_write;
    bus.ioaddr = is_write ? addr : ((addr == 2'b00) ? 2'b01 : addr);
    @(negedge clk);
    bus.iorw   = 1'b0;
    bus.ioaddr = 2'b11;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxd = 1'b1;
    bus.iorw   = 1'b0;
    bus.ioaddr = 2'b11;
    m_data = 8'h00; m_rda = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.rx_data, bus.rda, bus.ferr, bus.overrun} !== {m_data, m_rda, m_ferr, m_ovr}) begin
      errors++;
      $display("FAIL reset: got data=%h rda=%b ferr=%b ovr=%b want data=%h rda=%b ferr=%b ovr=%b",
               bus.rx_data, bus.rda, bus.ferr, bus.overrun, m_data, m_rda, m_ferr, m_ovr);
    end
    rst = 1'b0;
    drive_line(1'b1, 4);
  endtask

  task automatic test_glitch();
    drive_line(1'b0, 4);
    drive_line(1'b1, 40);
    @(negedge clk);
    checks++;
    if ({bus.rx_data, bus.rda, bus.ferr, bus.overrun} !== {m_data, m_rda, m_ferr, m_ovr}) begin
      errors++;
      $display("FAIL glitch: got data=%h rda=%b ferr=%b ovr=%b want data=%h rda=%b ferr=%b ovr=%b",
               bus.rx_data, bus.rda, bus.ferr, bus.overrun, m_data, m_rda, m_ferr, m_ovr);
    end
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1);
    @(negedge clk);
    checks++;
    if ({bus.rx_data, bus.rda, bus.ferr, bus.overrun} !== {m_data, m_rda, m_ferr, m_ovr}) begin
      errors++;
      $display("FAIL basic_a5: got data=%h rda=%b ferr=%b ovr=%b want data=%h rda=%b ferr=%b ovr=%b",
               bus.rx_data, bus.rda, bus.ferr, bus.overrun, m_data, m_rda, m_ferr, m_ovr);
    end
    do_noop(1'b1, 2'b00);
    do_noop(1'b0, 2'b10);
    checks++;
    if ({bus.rx_data, bus.rda, bus.overrun} !== {m_data, m_rda, m_ovr}) begin
      errors++;
      $display("FAIL noop_access: got data=%h rda=%b ovr=%b want data=%h rda=%b ovr=%b",
               bus.rx_data, bus.rda, bus.overrun, m_data, m_rda, m_ovr);
    end
    do_read();
    checks++;
    if ({bus.rx_data, bus.rda, bus.ferr, bus.overrun} !== {m_data, m_rda, m_ferr, m_ovr}) begin
      errors++;
      $display("FAIL basic_read: got data=%h rda=%b ferr=%b ovr=%b want data=%h rda=%b ferr=%b ovr=%b",
               bus.rx_data, bus.rda, bus.ferr, bus.overrun, m_data, m_rda, m_ferr, m_ovr);
    end
  endtask

  task automatic test_overrun();
    send_frame(8'h3C, 1'b1);
    model_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    model_frame(8'hC3, 1'b1);
    @(negedge clk);
    checks++;
    if ({bus.rx_data, bus.rda, bus.ferr, bus.overrun} !== {m_data, m_rda, m_ferr, m_ovr}) begin
      errors++;
      $display("FAIL overrun_set: got data=%h rda=%b ferr=%b ovr=%b want data=%h rda=%b ferr=%b ovr=%b",
               bus.rx_data, bus.rda, bus.ferr, bus.overrun, m_data, m_rda, m_ferr, m_ovr);
    end
    do_read();
    checks++;
    if ({bus.rx_data, bus.rda, bus.ferr, bus.overrun} !== {m_data, m_rda, m_ferr, m_ovr}) begin
      errors++;
      $display("FAIL overrun_clear: got data=%h rda=%b ferr=%b ovr=%b want data=%h rda=%b ferr=%b ovr=%b",
               bus.rx_data, bus.rda, bus.ferr, bus.overrun, m_data, m_rda, m_ferr, m_ovr);
    end
  endtask

  task automatic test_ferr();
    send_frame(8'h55, 1'b0);
    model_frame(8'h55, 1'b0);
    @(negedge clk);
    checks++;
    if ({bus.rx_data, bus.rda, bus.ferr, bus.overrun} !== {m_data, m_rda, m_ferr, m_ovr}) begin
      errors++;
      $display("FAIL ferr_bad_stop: got data=%h rda=%b ferr=%b ovr=%b want data=%h rda=%b ferr=%b ovr=%b",
               bus.rx_data, bus.rda, bus.ferr, bus.overrun, m_data, m_rda, m_ferr, m_ovr);
    end
    // Reads leave ferr alone
    do_read();
    send_frame(8'h0F, 1'b1);
    model_frame(8'h0F, 1'b1);
    @(negedge clk);
    checks++;
    if ({bus.rx_data, bus.rda, bus.ferr, bus.overrun} !== {m_data, m_rda, m_ferr, m_ovr}) begin
      errors++;
      $display("FAIL ferr_good_stop: got data=%h rda=%b ferr=%b ovr=%b want data=%h rda=%b ferr=%b ovr=%b",
               bus.rx_data, bus.rda, bus.ferr, bus.overrun, m_data, m_rda, m_ferr, m_ovr);
    end
    do_read();
  endtask

  task automatic test_reset_mid_frame();
    drive_line(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_line(1'b1, 16);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_data = 8'h00; m_rda = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    drive_line(1'b1, 16 * 5);
    @(negedge clk);
    checks++;
    if ({bus.rx_data, bus.rda, bus.ferr, bus.overrun} !== {m_data, m_rda, m_ferr, m_ovr}) begin
      errors++;
      $display("FAIL reset_mid: got data=%h rda=%b ferr=%b ovr=%b want data=%h rda=%b ferr=%b ovr=%b",
               bus.rx_data, bus.rda, bus.ferr, bus.overrun, m_data, m_rda, m_ferr, m_ovr);
    end
    send_frame(8'h81, 1'b1);
    model_frame(8'h81, 1'b1);
    @(negedge clk);
    checks++;
    if ({bus.rx_data, bus.rda, bus.ferr, bus.overrun} !== {m_data, m_rda, m_ferr, m_ovr}) begin
      errors++;
      $display("FAIL after_reset_81: got data=%h rda=%b ferr=%b ovr=%b want data=%h rda=%b ferr=%b ovr=%b",
               bus.rx_data, bus.rda, bus.ferr, bus.overrun, m_data, m_rda, m_ferr, m_ovr);
    end
    do_read();
  endtask

  // Read held through the stop bit, so it is active on the completion cycle itself
  task automatic test_read_on_completion();
    logic seen;
    seen = 1'b0;
    send_start_data(8'h7E);
    @(negedge clk);
    rxd        = 1'b1;
    bus.iorw   = 1'b1;
    bus.ioaddr = 2'b00;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rda === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    bus.iorw   = 1'b0;
    bus.ioaddr = 2'b11;
    model_frame(8'h7E, 1'b1);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL read_on_completion_timeout: got rda=%b want rda=1 within 200 cycles",
               bus.rda);
    end
    @(negedge clk);
    checks++;
    if ({bus.rx_data, bus.rda, bus.ferr, bus.overrun} !== {m_data, m_rda, m_ferr, m_ovr}) begin
      errors++;
      $display("FAIL read_on_completion: got data=%h rda=%b ferr=%b ovr=%b want data=%h rda=%b ferr=%b ovr=%b",
               bus.rx_data, bus.rda, bus.ferr, bus.overrun, m_data, m_rda, m_ferr, m_ovr);
    end
    drive_line(1'b1, 16);
    do_read();
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       stop;
    for (int n = 0; n < 16; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, stop);
      model_frame(d, stop);
      @(negedge clk);
      checks++;
      if ({bus.rx_data, bus.rda, bus.ferr, bus.overrun} !== {m_data, m_rda, m_ferr, m_ovr}) begin
        errors++;
        $display("FAIL random_frame[%0d]: got data=%h rda=%b ferr=%b ovr=%b want data=%h rda=%b ferr=%b ovr=%b",
                 n, bus.rx_data, bus.rda, bus.ferr, bus.overrun, m_data, m_rda, m_ferr, m_ovr);
      end
      if ($urandom_range(0, 1) == 1) do_noop($urandom_range(0, 1) == 1, 2'($urandom));
      if ($urandom_range(0, 2) != 0) begin
        do_read();
        checks++;
        if ({bus.rda, bus.overrun} !== {m_rda, m_ovr}) begin
          errors++;
          $display("FAIL random_read[%0d]: got rda=%b ovr=%b want rda=%b ovr=%b",
                   n, bus.rda, bus.overrun, m_rda, m_ovr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_basic();
    test_overrun();
    test_ferr();
    test_reset_mid_frame();
    test_read_on_completion();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
